instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width.
REQ-002 Parameter ADDR_W, default 11, program address width; depth = 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 program_counter  input  ADDR_W  fetch address from the control unit.
REQ-006 instruction  output  DATA_W  fetched word, registered.
REQ-007 ld_valid  input  1  load beat valid.
REQ-008 ld_data  input  DATA_W  load word.
REQ-009 ld_last  input  1  marks final load beat, qualified by ld_valid.
REQ-010 ld_ready  output  1  loader may transfer; beat accepted when ld_valid and ld_ready are both 1 at a rising edge.
REQ-011 reload  input  1  single-cycle request to restart loading; sampled only in RUN.
REQ-012 cpu_run  output  1  drives the control unit's active-low rst; 0 holds the processor in reset.
REQ-013 load_count  output  ADDR_W+1  number of words written since last entry to LOAD.
REQ-014 load_err  output  1  memory filled without ld_last.

Function
REQ-015 FSM has exactly two states, LOAD and RUN.
REQ-016 LOAD: ld_ready=1, cpu_run=0, instruction=0.
REQ-017 RUN: ld_ready=0, cpu_run=1.
REQ-018 Accepted beat in LOAD writes ld_data to mem[load_count[ADDR_W-1:0]] and increments load_count by 1 at the same edge.
REQ-019 Accepted beat with ld_last=1 writes the word, increments load_count, enters RUN next cycle, and leaves load_err=0.
REQ-020 Accepted beat making load_count equal 2**ADDR_W with ld_last=0 writes the word, enters RUN, and sets load_err=1.
REQ-021 Full memory with ld_last=1 on the final beat enters RUN with load_err=0.
REQ-022 load_count never exceeds 2**ADDR_W; no further writes occur once RUN is entered.
REQ-023 RUN: each rising edge registers instruction <= mem[program_counter] when program_counter < load_count, else 0 (NOP, opcode 00000); latency exactly one cycle.
REQ-024 First RUN cycle (cpu_run just asserted): instruction presents mem[program_counter] sampled at the entry edge, which is address 0 while the processor is in reset.
REQ-025 reload=1 in RUN: next edge enters LOAD, load_count=0, load_err=0, instruction=0, cpu_run=0.
REQ-026 reload in LOAD is ignored; ld_valid in RUN is ignored.
REQ-027 Memory contents are not cleared by reset or reload; words at or beyond load_count are masked by REQ-023.

Reset
REQ-028 rst=0 forces asynchronously: state=LOAD, load_count=0, load_err=0, instruction=0, ld_ready=1, cpu_run=0.
REQ-029 Reset mid-load discards the partial load count; reset in RUN returns to LOAD and holds the processor in reset.
REQ-030 On release, the first rising edge may accept a load beat.

Verification
REQ-031 Load 3 beats 16'h0801, 16'h1002, 16'h1803 (last on 3rd) -> load_count=3, cpu_run=1 the cycle after beat 3, load_err=0.
REQ-032 In RUN, program_counter 0,1,2,3 on successive edges -> instruction 16'h0801, 16'h1002, 16'h1803, 16'h0000 one cycle later each.
REQ-033 ld_valid toggling 1,0,1 with ld_ready=1 -> only 2 writes, load_count=2, addresses 0 and 1.
REQ-034 2048 beats with no ld_last -> RUN, load_err=1, load_count=2048; beat 2049 is ignored.
REQ-035 reload pulse in RUN -> cpu_run=0, ld_ready=1, load_count=0 next cycle; new 1-word load -> program_counter=1 returns 0.
REQ-036 rst asserted mid-load after 5 beats, between clock edges -> outputs take reset values immediately; load_count=0.

Source files
------------

// File: rtl/instruction_memory.sv
// Program store for a small processor: a streaming loader fills the memory while the
// core is held in reset, then registered fetches serve the control unit until a reload.
module instruction_memory #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] program_counter,
    output logic [DATA_W-1:0] instruction,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [CNT_W-1:0]  count_inc;
    logic              mem_full;
    logic              load_done;
    logic [CNT_W-1:0]  pc_ext;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] rd_word;

    assign accept    = (state == S_LOAD) && ld_valid;
    assign count_inc = load_count + CNT_W'(1);
    assign mem_full  = (count_inc == CNT_W'(DEPTH));
    assign load_done = accept && (ld_last || mem_full);
    assign pc_ext    = {1'b0, program_counter};
    assign wr_addr   = load_count[ADDR_W-1:0];

    // Forward the word being written so the entry-edge fetch sees the final beat.
    always_comb begin
        rd_word = mem[program_counter];
        if (accept && (program_counter == wr_addr)) begin
            rd_word = ld_data;
        end
    end

    // Storage is never cleared; words beyond load_count are masked on fetch.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_LOAD;
            load_count  <= '0;
            load_err    <= 1'b0;
            instruction <= '0;
            ld_ready    <= 1'b1;
            cpu_run     <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        load_count <= count_inc;
                    end
                    if (load_done) begin
                        state       <= S_RUN;
                        ld_ready    <= 1'b0;
                        cpu_run     <= 1'b1;
                        load_err    <= ~ld_last;
                        instruction <= (pc_ext < count_inc) ? rd_word : '0;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state       <= S_LOAD;
                        load_count  <= '0;
                        load_err    <= 1'b0;
                        instruction <= '0;
                        ld_ready    <= 1'b1;
                        cpu_run     <= 1'b0;
                    end else begin
                        instruction <= (pc_ext < load_count) ? rd_word : '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed scenarios plus randomized
// programs compared against a transaction-level model of the load/fetch rules.
module tb_instruction_memory;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] program_counter;
    logic [DATA_W-1:0] instruction;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              reload;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
    logic              load_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_count;
    bit                m_run;
    bit                m_err;
    logic [DATA_W-1:0] m_instr;

    instruction_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .program_counter (program_counter),
        .instruction     (instruction),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_last         (ld_last),
        .ld_ready        (ld_ready),
        .reload          (reload),
        .cpu_run         (cpu_run),
        .load_count      (load_count),
        .load_err        (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] model_fetch();
        return (int'(program_counter) < m_count) ? m_mem[program_counter] : '0;
    endfunction

    // One clock edge; model applies the rules to the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        if (!m_run) begin
            if (ld_valid) begin
                m_mem[m_count] = ld_data;
                m_count++;
                if (ld_last || m_count == DEPTH) begin
                    m_run = 1'b1;
                    m_err = !ld_last;
                end
            end
            m_instr = m_run ? model_fetch() : '0;
        end else if (reload) begin
            m_run   = 1'b0;
            m_count = 0;
            m_err   = 1'b0;
            m_instr = '0;
        end else begin
            m_instr = model_fetch();
        end
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        reload   = 1'b0;
        ld_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        program_counter = '0;
        idle_inputs();
        m_count = 0; m_run = 1'b0; m_err = 1'b0; m_instr = '0;
        #23;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL reset_cpu_run got=%0b exp=0", cpu_run); end
        checks++; if (load_count !== 12'd0) begin failures++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%0b exp=0", load_err); end
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL reset_instruction got=%h exp=0000", instruction); end
        #4 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [DATA_W-1:0] words [3];
        logic [DATA_W-1:0] exp_fetch [4];
        words[0] = 16'h0801; words[1] = 16'h1002; words[2] = 16'h1803;
        exp_fetch[0] = 16'h0801; exp_fetch[1] = 16'h1002; exp_fetch[2] = 16'h1803; exp_fetch[3] = 16'h0000;
        program_counter = '0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            tick();
            checks++; if (load_count !== 12'(i + 1)) begin failures++; $display("FAIL basic_count beat=%0d got=%0d exp=%0d", i, load_count, i + 1); end
            checks++; if (cpu_run !== (i == 2)) begin failures++; $display("FAIL basic_cpu_run beat=%0d got=%0b exp=%0b", i, cpu_run, i == 2); end
        end
        idle_inputs();
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL basic_load_err got=%0b exp=0", load_err); end
        checks++; if (instruction !== 16'h0801) begin failures++; $display("FAIL basic_entry_fetch got=%h exp=0801", instruction); end
        for (int k = 0; k < 4; k++) begin
            program_counter = ADDR_W'(k);
            tick();
            checks++; if (instruction !== exp_fetch[k]) begin failures++; $display("FAIL basic_fetch pc=%0d got=%h exp=%h", k, instruction, exp_fetch[k]); end
        end
    endtask

    task automatic test_valid_gaps();
        logic [DATA_W-1:0] d0, d1;
        bit pattern [3];
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1;
        d0 = 16'(($urandom() & 32'hFFFF) | 32'h1);
        d1 = 16'(($urandom() & 32'hFFFF) | 32'h2);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = pattern[i];
            ld_data  = (i == 0) ? d0 : (i == 2) ? d1 : 16'hDEAD;
            tick();
        end
        idle_inputs();
        checks++; if (load_count !== 12'd2) begin failures++; $display("FAIL gaps_count got=%0d exp=2", load_count); end
        ld_valid = 1'b1; ld_data = 16'h7777; ld_last = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            program_counter = ADDR_W'(k);
            tick();
            checks++; if (instruction !== ((k == 0) ? d0 : d1)) begin failures++; $display("FAIL gaps_fetch pc=%0d got=%h exp=%h", k, instruction, (k == 0) ? d0 : d1); end
        end
    endtask

    task automatic test_random_programs();
        int n;
        int acc;
        for (int r = 0; r < 4; r++) begin
            reload = 1'b1;
            tick();
            n = $urandom_range(1, 40);
            acc = 0;
            while (acc < n) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_data  = 16'($urandom());
                ld_last  = ld_valid && (acc == n - 1);
                reload   = 1'($urandom_range(0, 1));
                program_counter = ADDR_W'($urandom());
                tick();
                if (ld_valid) acc++;
                checks++; if (load_count !== 12'(m_count) || cpu_run !== m_run || ld_ready !== !m_run) begin
                    failures++; $display("FAIL rand_load round=%0d count=%0d/%0d run=%0b/%0b ready=%0b", r, load_count, m_count, cpu_run, m_run, ld_ready);
                end
                checks++; if (instruction !== m_instr) begin failures++; $display("FAIL rand_load_instr round=%0d got=%h exp=%h", r, instruction, m_instr); end
            end
            idle_inputs();
            for (int k = 0; k < 30; k++) begin
                program_counter = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, n + 4)) : ADDR_W'($urandom());
                ld_valid = 1'($urandom_range(0, 1));
                ld_data  = 16'($urandom());
                tick();
                checks++; if (instruction !== m_instr) begin failures++; $display("FAIL rand_fetch round=%0d pc=%0d got=%h exp=%h", r, program_counter, instruction, m_instr); end
                checks++; if (load_count !== 12'(m_count)) begin failures++; $display("FAIL rand_fetch_count got=%0d exp=%0d", load_count, m_count); end
            end
            idle_inputs();
        end
    endtask

    task automatic test_full(input bit with_last);
        logic [DATA_W-1:0] w0;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'($urandom());
            ld_last  = with_last && (i == DEPTH - 1);
            if (i == 0) w0 = ld_data;
            tick();
        end
        idle_inputs();
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL full_cpu_run last=%0b got=%0b exp=1", with_last, cpu_run); end
        checks++; if (load_err !== !with_last) begin failures++; $display("FAIL full_load_err last=%0b got=%0b exp=%0b", with_last, load_err, !with_last); end
        checks++; if (load_count !== 12'd2048) begin failures++; $display("FAIL full_count got=%0d exp=2048", load_count); end
        ld_valid = 1'b1; ld_data = ~w0; program_counter = '0;
        tick();
        idle_inputs();
        tick();
        checks++; if (load_count !== 12'd2048) begin failures++; $display("FAIL full_extra_count got=%0d exp=2048", load_count); end
        checks++; if (instruction !== w0) begin failures++; $display("FAIL full_extra_word got=%h exp=%h", instruction, w0); end
        program_counter = 11'd2047;
        tick();
        checks++; if (instruction !== m_instr) begin failures++; $display("FAIL full_top_word got=%h exp=%h", instruction, m_instr); end
    endtask

    task automatic test_reload();
        logic [DATA_W-1:0] w;
        w = 16'($urandom()) | 16'h0100;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++; if (cpu_run !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL reload_ctrl run=%0b ready=%0b exp run=0 ready=1", cpu_run, ld_ready); end
        checks++; if (load_count !== 12'd0 || load_err !== 1'b0 || instruction !== 16'h0) begin
            failures++; $display("FAIL reload_state count=%0d err=%0b instr=%h exp 0/0/0000", load_count, load_err, instruction);
        end
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL reload_in_load got=%0b exp=0", cpu_run); end
        ld_valid = 1'b1; ld_data = w; ld_last = 1'b1; program_counter = 11'd1;
        tick();
        idle_inputs();
        tick();
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL reload_masked pc=1 got=%h exp=0000", instruction); end
        program_counter = '0;
        tick();
        checks++; if (instruction !== w) begin failures++; $display("FAIL reload_word pc=0 got=%h exp=%h", instruction, w); end
    endtask

    task automatic test_reset_midload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = 16'($urandom());
            tick();
        end
        idle_inputs();
        checks++; if (load_count !== 12'd5) begin failures++; $display("FAIL midload_count got=%0d exp=5", load_count); end
        #2 rst = 1'b0;
        #1;
        m_count = 0; m_run = 1'b0; m_err = 1'b0; m_instr = '0;
        checks++; if (load_count !== 12'd0) begin failures++; $display("FAIL midload_rst_count got=%0d exp=0", load_count); end
        checks++; if (ld_ready !== 1'b1 || cpu_run !== 1'b0 || load_err !== 1'b0 || instruction !== 16'h0) begin
            failures++; $display("FAIL midload_rst_outputs ready=%0b run=%0b err=%0b instr=%h", ld_ready, cpu_run, load_err, instruction);
        end
        #2 rst = 1'b1;
        ld_valid = 1'b1; ld_data = 16'hA5A5; ld_last = 1'b1; program_counter = '0;
        tick();
        idle_inputs();
        checks++; if (load_count !== 12'd1 || cpu_run !== 1'b1) begin failures++; $display("FAIL post_rst_beat count=%0d run=%0b exp 1/1", load_count, cpu_run); end
        checks++; if (instruction !== 16'hA5A5) begin failures++; $display("FAIL post_rst_entry got=%h exp=a5a5", instruction); end
        #2 rst = 1'b0;
        #1;
        m_count = 0; m_run = 1'b0; m_err = 1'b0; m_instr = '0;
        checks++; if (cpu_run !== 1'b0 || ld_ready !== 1'b1 || load_count !== 12'd0) begin
            failures++; $display("FAIL run_rst run=%0b ready=%0b count=%0d exp 0/1/0", cpu_run, ld_ready, load_count);
        end
        #2 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_valid_gaps();
        test_random_programs();
        test_full(1'b0);
        test_full(1'b1);
        test_reload();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
